// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM state type and
// nibble-CPU opcode constants used to build test programs.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } imem_state_t;

  // Nibble-CPU opcodes (upper nibble of an instruction word)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_JMP = 4'hA;

endpackage

// File: rtl/instruction_memory_loadable_if.sv
// Load/fetch bus of the loadable instruction memory.
//  master: program loader + CPU fetch stage (drives load_start, ld_*, fetch_en/addr)
//  slave : the memory (drives ld_ready, fetch_data/valid, busy, loaded, load_count)
interface instruction_memory_loadable_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              load_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              busy;
  logic              loaded;
  logic [ADDR_W:0]   load_count;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, fetch_en, fetch_addr,
    input  ld_ready, fetch_data, fetch_valid, busy, loaded, load_count
  );

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, fetch_en, fetch_addr,
    output ld_ready, fetch_data, fetch_valid, busy, loaded, load_count
  );
endinterface

// File: rtl/imem_ram_1r1w.sv
// Plain synchronous RAM: one write port, one registered read port.
// The array is not reset; the owner clears it by writing.
//  clk         clock
//  we/waddr/wdata  write port
//  re/raddr        read enable/address; rdata updates one cycle later, holds when re=0
module imem_ram_1r1w #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_memory_loadable.sv
// Run-time loadable instruction store for the nibble CPU.
// A byte-stream load port fills the memory after it has been zero-cleared;
// the CPU then reads it through a 1-cycle registered fetch port.
//  clk    clock, rising edge
//  rst_n  synchronous active-low reset (re-clears memory)
//  bus    slave side of instruction_memory_loadable_if (load + fetch ports,
//         busy/loaded/load_count status)
module instruction_memory_loadable
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input logic                          clk,
  input logic                          rst_n,
  instruction_memory_loadable_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  imem_state_t       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              reload_q;   // CLEAR entered via load_start -> continue to LOAD
  logic              zero_q;     // force fetch_data to 0 (reset / out-of-range fetch)

  logic              accept_c;
  logic              fetch_hit_c;
  logic              oor_c;
  logic              we_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rdata_c;

  // ld_ready is high exactly in LOAD, so it doubles as the state qualifier
  assign accept_c    = bus.ld_valid && bus.ld_ready;
  assign fetch_hit_c = (state_q == ST_RUN) && bus.fetch_en;
  assign oor_c       = {1'b0, bus.fetch_addr} >= DEPTH_CNT;
  assign we_c        = (state_q == ST_CLEAR) || accept_c;
  assign wdata_c     = (state_q == ST_CLEAR) ? '0 : bus.ld_data;

  imem_ram_1r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we_c),
    .waddr (ptr_q),
    .wdata (wdata_c),
    .re    (fetch_hit_c && !oor_c),
    .raddr (bus.fetch_addr),
    .rdata (rdata_c)
  );

  // RAM output is already registered; zero_q masks it after reset and for out-of-range reads
  assign bus.fetch_data = zero_q ? '0 : rdata_c;

  // Control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_CLEAR;
      ptr_q           <= '0;
      reload_q        <= 1'b0;
      zero_q          <= 1'b1;
      bus.ld_ready    <= 1'b0;
      bus.fetch_valid <= 1'b0;
      bus.busy        <= 1'b1;
      bus.loaded      <= 1'b0;
      bus.load_count  <= '0;
    end else begin
      bus.fetch_valid <= fetch_hit_c;
      if (fetch_hit_c) begin
        zero_q <= oor_c;
      end

      case (state_q)
        ST_CLEAR: begin
          if (ptr_q == LAST_PTR) begin
            ptr_q <= '0;
            if (reload_q) begin
              state_q      <= ST_LOAD;
              bus.ld_ready <= 1'b1;
            end else begin
              state_q  <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end

        ST_IDLE: begin
          if (bus.load_start) begin
            state_q        <= ST_CLEAR;
            reload_q       <= 1'b1;
            bus.busy       <= 1'b1;
            bus.load_count <= '0;
          end
        end

        ST_LOAD: begin
          if (accept_c) begin
            if (bus.load_count != DEPTH_CNT) begin
              bus.load_count <= bus.load_count + (ADDR_W + 1)'(1);
            end
            // Last slot ends the load regardless of ld_last; ptr never wraps
            if (bus.ld_last || (ptr_q == LAST_PTR)) begin
              state_q      <= ST_RUN;
              ptr_q        <= '0;
              bus.ld_ready <= 1'b0;
              bus.busy     <= 1'b0;
              bus.loaded   <= 1'b1;
            end else begin
              ptr_q <= ptr_q + ADDR_W'(1);
            end
          end
        end

        ST_RUN: begin
          if (bus.load_start) begin
            state_q        <= ST_CLEAR;
            reload_q       <= 1'b1;
            bus.busy       <= 1'b1;
            bus.loaded     <= 1'b0;
            bus.load_count <= '0;
          end
        end

        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Self-checking bench for instruction_memory_loadable: directed scenarios plus
// randomized load/fetch sequences against an array model of the memory.
module tb_instruction_memory_loadable;
  import imem_pkg::*;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;

  instruction_memory_loadable_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  instruction_memory_loadable #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: memory contents, whether fetches are served, last fetched word
  logic [7:0] model [DEPTH];
  bit         running;
  logic [7:0] exp_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  // Wait for the post-reset clear to finish; it must take exactly DEPTH cycles
  task automatic wait_idle();
    int c = 0;
    while (bus.busy && c < 200) begin
      step();
      c++;
    end
    check("reset_clear_len", c, DEPTH);
    check("idle_busy", bus.busy, 0);
    check("idle_loaded", bus.loaded, 0);
  endtask

  task automatic fetch(input bit en, input logic [4:0] a);
    bus.fetch_en   = en;
    bus.fetch_addr = a;
    step();
    if (en && running) begin
      check("fetch_valid", bus.fetch_valid, 1);
      check("fetch_data", bus.fetch_data, model[a]);
      exp_hold = model[a];
    end else begin
      check("fetch_idle_valid", bus.fetch_valid, 0);
      check("fetch_hold", bus.fetch_data, exp_hold);
    end
    bus.fetch_en = 1'b0;
  endtask

  // Pulse load_start (optionally with a fetch in the same cycle) and wait for LOAD
  task automatic start_load(input bit fetch_too, input logic [4:0] a);
    int c = 0;
    bus.load_start = 1'b1;
    bus.fetch_en   = fetch_too;
    bus.fetch_addr = a;
    step();
    bus.load_start = 1'b0;
    bus.fetch_en   = 1'b0;
    if (fetch_too && running) begin
      check("reload_fetch_valid", bus.fetch_valid, 1);
      check("reload_fetch_data", bus.fetch_data, model[a]);
      exp_hold = model[a];
    end
    check("start_busy", bus.busy, 1);
    check("start_loaded", bus.loaded, 0);
    check("start_load_count", bus.load_count, 0);
    running = 0;
    model_clear();
    while (!bus.ld_ready && c < 200) begin
      step();
      c++;
    end
    check("reload_clear_len", c, DEPTH);
    check("load_busy", bus.busy, 1);
  endtask

  // Stream words; noise inserts ld_valid gaps and stray load_start pulses
  task automatic stream(input logic [7:0] w[$], input bit with_last, input bit noise);
    int n = w.size();
    for (int i = 0; i < n; i++) begin
      if (noise && ($urandom_range(0, 3) == 0)) begin
        bus.ld_valid   = 1'b0;
        bus.ld_data    = 8'($urandom);
        bus.load_start = 1'($urandom_range(0, 1));
        step();
      end
      bus.ld_valid   = 1'b1;
      bus.ld_data    = w[i];
      bus.ld_last    = with_last && (i == n - 1);
      bus.load_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      model[i] = w[i];
    end
    bus.ld_valid   = 1'b0;
    bus.ld_last    = 1'b0;
    bus.load_start = 1'b0;
    running = 1;
    check("end_ld_ready", bus.ld_ready, 0);
    check("end_loaded", bus.loaded, 1);
    check("end_busy", bus.busy, 0);
    check("end_load_count", bus.load_count, n);
  endtask

  initial begin
    logic [7:0] q[$];
    bus.load_start = 0; bus.ld_valid = 0; bus.ld_data = 0; bus.ld_last = 0;
    bus.fetch_en = 0; bus.fetch_addr = 0;
    running = 0; exp_hold = 8'h00;
    model_clear();

    // Reset values
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_busy", bus.busy, 1);
    check("rst_loaded", bus.loaded, 0);
    check("rst_ld_ready", bus.ld_ready, 0);
    check("rst_fetch_valid", bus.fetch_valid, 0);
    check("rst_fetch_data", bus.fetch_data, 0);
    check("rst_load_count", bus.load_count, 0);
    wait_idle();

    // Fetch in IDLE is not served
    fetch(1'b1, 5'd3);

    // Three-word program
    start_load(1'b0, 5'd0);
    q = '{{OP_LDI, 4'hC}, {OP_NOP, 4'h0}, {OP_LDI, 4'h8}};
    stream(q, 1'b1, 1'b0);
    fetch(1'b1, 5'd2);
    fetch(1'b1, 5'd7);
    // Back-to-back fetches then hold
    fetch(1'b1, 5'd0);
    fetch(1'b1, 5'd1);
    fetch(1'b1, 5'd2);
    fetch(1'b0, 5'd5);
    fetch(1'b0, 5'd0);

    // Reload from RUN with a same-cycle fetch, then a one-word program
    start_load(1'b1, 5'd0);
    q = '{{OP_JMP, 4'hA}};
    stream(q, 1'b1, 1'b0);
    fetch(1'b1, 5'd0);
    fetch(1'b1, 5'd1);

    // Full load without ld_last: auto-end at DEPTH, extra word ignored
    start_load(1'b0, 5'd0);
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom_range(1, 255)));
    stream(q, 1'b0, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h77;
    step();
    bus.ld_valid = 1'b0;
    check("extra_ld_ready", bus.ld_ready, 0);
    check("extra_load_count", bus.load_count, DEPTH);
    check("extra_loaded", bus.loaded, 1);
    fetch(1'b1, 5'd31);
    fetch(1'b1, 5'd0);

    // Randomized programs and fetch traffic
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, DEPTH);
      bit last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      start_load(1'($urandom_range(0, 1)), 5'($urandom));
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      stream(q, last, 1'b1);
      for (int k = 0; k < 20; k++) fetch(1'($urandom_range(0, 3) != 0), 5'($urandom));
    end

    // Reset in the middle of a load
    start_load(1'b0, 5'd0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h5A;
    step();
    bus.ld_data  = 8'h6B;
    step();
    bus.ld_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    running = 0;
    exp_hold = 8'h00;
    model_clear();
    check("midrst_busy", bus.busy, 1);
    check("midrst_loaded", bus.loaded, 0);
    check("midrst_ld_ready", bus.ld_ready, 0);
    check("midrst_load_count", bus.load_count, 0);
    check("midrst_fetch_data", bus.fetch_data, 0);
    wait_idle();
    start_load(1'b0, 5'd0);
    q = '{8'h11};
    stream(q, 1'b1, 1'b0);
    fetch(1'b1, 5'd0);
    fetch(1'b1, 5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
